// File: rtl/mem_stage_pkg.sv
// Shared widths, load op codes and bus layouts for the MEM pipeline stage.
// Struct field order matches the packed bus layouts exchanged with EX, WB and ID.
package mem_stage_pkg;

    localparam int ES_TO_MS_WD = 75;
    localparam int MS_TO_WS_WD = 70;
    localparam int MS_FWD_WD   = 39;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef struct packed {
        logic        wait_resp;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] alu_result;
    } es_to_ms_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] final_result;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_we;
        logic        fwd_stall;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_fwd_t;

    // Internal state made visible for checkers.
    typedef struct packed {
        logic ms_valid;
        logic resp_got;
        logic drop_one;
    } ms_dbg_t;

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX->MEM, MEM->WB, data-SRAM response, flush and forwarding.
// Handshake: a transfer happens on a rising edge where valid and the receiver's allow_in are both 1.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                   es_to_ms_valid;
    logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
    logic                   ms_allow_in;
    logic                   ms_to_ws_valid;
    logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
    logic                   ws_allow_in;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic                   flush;
    logic [MS_FWD_WD-1:0]   ms_fwd_bus;
    ms_dbg_t                dbg;

    modport master (
        input  es_to_ms_valid, es_to_ms_bus, ws_allow_in,
        input  data_sram_data_ok, data_sram_rdata, flush,
        output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, dbg
    );

    modport slave (
        output es_to_ms_valid, es_to_ms_bus, ws_allow_in,
        output data_sram_data_ok, data_sram_rdata, flush,
        input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, dbg
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/half of a 32-bit load word.
// Misaligned halves are not trapped here; the address check lives in EX.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (ld_op)
            LD_W:    result = rdata;
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_BU:   result = {24'b0, byte_sel};
            LD_HU:   result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one instruction from EX, waits for its data-SRAM response,
// buffers a response that arrives while WB stalls, and drops responses of flushed loads.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.master bus
);

    es_to_ms_t   payload;
    logic        ms_valid;
    logic        resp_got;
    logic        drop_one;
    logic [31:0] rdata_buf;

    logic        rsp;
    logic        waiting;
    logic        ms_ready_go;
    logic        allow_in;
    logic        to_ws_valid;
    logic        leave;
    logic        accept;
    logic [31:0] ld_data;
    logic [31:0] aligned;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;
    ms_fwd_t     fwd_out;

    always_comb begin
        rsp         = bus.data_sram_data_ok && !drop_one;
        waiting     = ms_valid && payload.wait_resp && !resp_got;
        ms_ready_go = !payload.wait_resp || resp_got || rsp;
        allow_in    = !ms_valid || (ms_ready_go && bus.ws_allow_in);
        to_ws_valid = ms_valid && ms_ready_go && !bus.flush;
        leave       = to_ws_valid && bus.ws_allow_in;
        accept      = bus.es_to_ms_valid && allow_in && !bus.flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_valid <= 1'b0;
            payload  <= '0;
        end else begin
            if (bus.flush) begin
                ms_valid <= 1'b0;
            end else if (allow_in) begin
                ms_valid <= bus.es_to_ms_valid;
            end
            if (accept) begin
                payload <= es_to_ms_t'(bus.es_to_ms_bus);
            end
        end
    end

    // A response that WB cannot take this cycle is parked until the instruction leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_got  <= 1'b0;
            rdata_buf <= '0;
        end else if (bus.flush || leave) begin
            resp_got <= 1'b0;
        end else if (rsp && waiting && !bus.ws_allow_in) begin
            resp_got  <= 1'b1;
            rdata_buf <= bus.data_sram_rdata;
        end
    end

    // A killed load whose request is still in flight owes us one response to discard.
    // If the owed response arrives in the same cycle a new one becomes owed, the flag stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_one <= 1'b0;
        end else if (bus.flush && waiting && !rsp) begin
            drop_one <= 1'b1;
        end else if (bus.data_sram_data_ok && drop_one) begin
            drop_one <= 1'b0;
        end
    end

    assign ld_data = resp_got ? rdata_buf : bus.data_sram_rdata;

    load_align u_load_align (
        .ld_op  (payload.ld_op),
        .addr   (payload.alu_result[1:0]),
        .rdata  (ld_data),
        .result (aligned)
    );

    assign final_result = payload.res_from_mem ? aligned : payload.alu_result;

    always_comb begin
        ws_out.rf_we         = payload.rf_we;
        ws_out.dest          = payload.dest;
        ws_out.pc            = payload.pc;
        ws_out.final_result  = final_result;
        fwd_out.fwd_we       = ms_valid && payload.rf_we;
        fwd_out.fwd_stall    = ms_valid && payload.res_from_mem && !ms_ready_go;
        fwd_out.dest         = payload.dest;
        fwd_out.final_result = final_result;
    end

    assign bus.ms_allow_in    = allow_in;
    assign bus.ms_to_ws_valid = to_ws_valid;
    assign bus.ms_to_ws_bus   = ws_out;
    assign bus.ms_fwd_bus     = fwd_out;
    assign bus.dbg            = '{ms_valid: ms_valid, resp_got: resp_got, drop_one: drop_one};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB payloads are queued at issue and
// compared when the stage hands an instruction to WB.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [MS_TO_WS_WD-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [74:0] mk_bus(logic w, logic r, logic [2:0] op, logic we,
                                           logic [4:0] d, logic [31:0] pc, logic [31:0] alu);
        return {w, r, op, we, d, pc, alu};
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] op, logic [1:0] a, logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> (8 * a);
        h = a[1] ? (rd >> 16) : rd;
        case (op)
            3'b001:  return {{24{b[7]}}, b[7:0]};
            3'b010:  return {{16{h[15]}}, h[15:0]};
            3'b011:  return {24'h0, b[7:0]};
            3'b100:  return {16'h0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    // Called #1 after each falling edge, with inputs for the coming rising edge in place.
    task automatic monitor();
        logic [MS_TO_WS_WD-1:0] e;
        if (bus_if.data_sram_data_ok && !bus_if.dbg.drop_one)
            check("rsp_target", {79'h0, bus_if.dbg.ms_valid && !bus_if.dbg.resp_got}, 80'h1);
        if (bus_if.ms_to_ws_valid && bus_if.ws_allow_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {10'h0, bus_if.ms_to_ws_bus}, 80'h0);
            end else begin
                e = exp_q.pop_front();
                check("ws_bus", {10'h0, bus_if.ms_to_ws_bus}, {10'h0, e});
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allow_in       = 1'b1;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = $urandom;
        bus_if.flush             = 1'b0;
    endtask

    task automatic send(input logic [74:0] b, input logic [69:0] e);
        bit took;
        took = 1'b0;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = b;
        for (int n = 0; n < 20 && !took; n++) begin
            #1;
            took = bus_if.ms_allow_in && !bus_if.flush;
            monitor();
            @(negedge clk);
        end
        bus_if.es_to_ms_valid = 1'b0;
        if (took) exp_q.push_back(e);
        else check("send_timeout", 80'h0, 80'h1);
    endtask

    task automatic do_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rd,
                           input logic [31:0] exp_res, input int delay, input int stall);
        logic [4:0]  d;
        logic [31:0] pc;
        logic [31:0] alu;
        d   = 5'($urandom_range(1, 31));
        pc  = $urandom & 32'hFFFF_FFFC;
        alu = ($urandom & 32'hFFFF_FFFC) | {30'h0, a};
        send(mk_bus(1'b1, 1'b1, op, 1'b1, d, pc, alu), {1'b1, d, pc, exp_res});
        for (int i = 0; i < delay; i++) begin
            bus_if.data_sram_data_ok = 1'b0;
            bus_if.data_sram_rdata   = $urandom;
            #1;
            check("ld_wait_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
            check("ld_wait_allow", {79'h0, bus_if.ms_allow_in}, 80'h0);
            check("ld_wait_stall", {79'h0, bus_if.ms_fwd_bus[37]}, 80'h1);
            monitor();
            @(negedge clk);
        end
        bus_if.ws_allow_in       = (stall == 0);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = rd;
        #1;
        check("ld_done_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h1);
        monitor();
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = ~rd ^ $urandom;
        for (int i = 0; i < stall; i++) begin
            #1;
            check("ld_held_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h1);
            check("ld_held_buf", {79'h0, bus_if.dbg.resp_got}, 80'h1);
            monitor();
            @(negedge clk);
        end
        if (stall > 0) begin
            bus_if.ws_allow_in = 1'b1;
            tick();
        end
    endtask

    task automatic do_alu(input logic [4:0] d, input logic [31:0] alu);
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        send(mk_bus(1'b0, 1'b0, 3'b000, 1'b1, d, pc, alu), {1'b1, d, pc, alu});
        tick();
    endtask

    // Raise reset between clock edges and confirm the state drops without a clock.
    task automatic pulse_rst(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_valid"}, {79'h0, bus_if.dbg.ms_valid}, 80'h0);
        check({tag, "_dbg"}, {77'h0, bus_if.dbg}, 80'h0);
        check({tag, "_out"}, {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        logic [4:0]  d;
        logic [31:0] pc;
        logic [31:0] rd;
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        #1;
        check("rst_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
        check("rst_bus", {10'h0, bus_if.ms_to_ws_bus}, 80'h0);
        check("rst_fwd", {41'h0, bus_if.ms_fwd_bus}, 80'h0);
        check("rst_dbg", {77'h0, bus_if.dbg}, 80'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ALU op reaches WB one cycle after acceptance.
        pc = 32'h1C00_0000;
        send(mk_bus(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, pc, 32'h1234_5678), {1'b1, 5'd5, pc, 32'h1234_5678});
        #1;
        check("alu_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h1);
        check("alu_fwd", {41'h0, bus_if.ms_fwd_bus}, {41'h0, 1'b1, 1'b0, 5'd5, 32'h1234_5678});
        monitor();
        @(negedge clk);

        // Sub-word loads with an immediate response.
        do_load(LD_B,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 0, 0);
        do_load(LD_BU, 2'd3, 32'h80FF_0000, 32'h0000_0080, 0, 0);
        do_load(LD_H,  2'd2, 32'h80FF_0000, 32'hFFFF_80FF, 0, 0);
        do_load(LD_HU, 2'd2, 32'h80FF_0000, 32'h0000_80FF, 0, 0);

        // Late response and a response held across a WB stall.
        do_load(LD_W, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 0);
        do_load(LD_B, 2'd1, 32'h0000_7F00, 32'h0000_007F, 1, 3);

        // Back-to-back ALU ops, then a third blocked by WB.
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk_bus(1'b0, 1'b0, 3'b000, 1'b1, 5'd1, 32'h100, 32'hA1);
        #1;
        check("pair_a_allow", {79'h0, bus_if.ms_allow_in}, 80'h1);
        monitor();
        @(negedge clk);
        exp_q.push_back({1'b1, 5'd1, 32'h100, 32'hA1});
        bus_if.es_to_ms_bus = mk_bus(1'b0, 1'b0, 3'b000, 1'b0, 5'd2, 32'h104, 32'hB2);
        #1;
        check("pair_b_allow", {79'h0, bus_if.ms_allow_in}, 80'h1);
        monitor();
        @(negedge clk);
        exp_q.push_back({1'b0, 5'd2, 32'h104, 32'hB2});
        bus_if.es_to_ms_bus = mk_bus(1'b0, 1'b0, 3'b000, 1'b1, 5'd3, 32'h108, 32'hC3);
        bus_if.ws_allow_in  = 1'b0;
        #1;
        check("pair_c_block", {79'h0, bus_if.ms_allow_in}, 80'h0);
        monitor();
        @(negedge clk);
        bus_if.ws_allow_in = 1'b1;
        #1;
        check("pair_c_allow", {79'h0, bus_if.ms_allow_in}, 80'h1);
        monitor();
        @(negedge clk);
        exp_q.push_back({1'b1, 5'd3, 32'h108, 32'hC3});
        bus_if.es_to_ms_valid = 1'b0;
        tick();

        // Flush while waiting: the stale response must not complete the next load.
        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, 5'd7, 32'h200, 32'h1000), {1'b1, 5'd7, 32'h200, 32'h0});
        bus_if.flush = 1'b1;
        #1;
        check("flush_out_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
        monitor();
        @(negedge clk);
        bus_if.flush = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("flush_killed", {79'h0, bus_if.dbg.ms_valid}, 80'h0);
        check("flush_drop_set", {79'h0, bus_if.dbg.drop_one}, 80'h1);
        monitor();
        @(negedge clk);
        rd = 32'h1357_9BDF;
        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, 5'd8, 32'h204, 32'h1004), {1'b1, 5'd8, 32'h204, rd});
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        check("stale_ignored", {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
        monitor();
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        check("drop_cleared", {79'h0, bus_if.dbg.drop_one}, 80'h0);
        monitor();
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = rd;
        #1;
        check("own_data_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h1);
        monitor();
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b0;

        // Flush coinciding with the response: data is dropped, nothing owed afterwards.
        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, 5'd9, 32'h208, 32'h1008), {1'b1, 5'd9, 32'h208, 32'h0});
        bus_if.flush             = 1'b1;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h0BAD_0BAD;
        #1;
        check("flush_rsp_valid", {79'h0, bus_if.ms_to_ws_valid}, 80'h0);
        monitor();
        @(negedge clk);
        set_idle();
        void'(exp_q.pop_back());
        #1;
        check("flush_rsp_nodrop", {79'h0, bus_if.dbg.drop_one}, 80'h0);
        monitor();
        @(negedge clk);
        do_load(LD_HU, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD, 0, 0);

        // Asynchronous reset with a buffered response, then with a drop pending.
        d = 5'd10;
        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, d, 32'h300, 32'h2000), {1'b1, d, 32'h300, 32'h5555_AAAA});
        bus_if.ws_allow_in       = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h5555_AAAA;
        tick();
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        check("pre_rst_buf", {79'h0, bus_if.dbg.resp_got}, 80'h1);
        pulse_rst("rst_buf");
        void'(exp_q.pop_back());

        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, 5'd11, 32'h304, 32'h2004), {1'b1, 5'd11, 32'h304, 32'h0});
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        void'(exp_q.pop_back());
        send(mk_bus(1'b1, 1'b1, LD_W, 1'b1, 5'd12, 32'h308, 32'h2008), {1'b1, 5'd12, 32'h308, 32'h0});
        #1;
        check("pre_rst_drop", {78'h0, bus_if.dbg.ms_valid, bus_if.dbg.drop_one}, 80'h3);
        pulse_rst("rst_drop");
        void'(exp_q.pop_back());

        // Restart with random traffic.
        do_alu(5'd13, 32'h0BAD_CAFE);
        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [1:0] a;
            if ($urandom_range(0, 2) == 0) begin
                do_alu(5'($urandom_range(1, 31)), $urandom);
            end else begin
                op = 3'($urandom_range(0, 7));
                a  = 2'($urandom_range(0, 3));
                rd = $urandom;
                do_load(op, a, rd, model_load(op, a, rd), $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end

        tick();
        check("q_empty", 80'(exp_q.size()), 80'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
